systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream feeder for a systolic PE array. Accepts one N-element activation vector per handshake and buffers it in a small FIFO.
- Drives row i of the array's in_a/in_valid inputs delayed by i cycles, producing the diagonal wavefront the array needs.
- Frames are delimited by in_last. After a frame's last vector, the feeder drains the skew pipeline and pulses done before it starts the next frame, so partial sums of successive frames never interleave.

Parameters:
- BitSize, 8, activation width in bits; matches the PE in_a width.
- N, 4, number of array rows, i.e. vector elements (N >= 2).
- Depth, 4, input FIFO depth in vectors (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- res_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input vector valid.
- in_ready  out  1  FIFO can accept a vector.
- in_data  in  N*BitSize  element k at bits [k*BitSize +: BitSize].
- in_last  in  1  marks the final vector of a frame; qualified by in_valid.
- stall  in  1  freezes FIFO pop, the skew pipeline and the FSM.
- out_a  out  N*BitSize  row i activation at bits [i*BitSize +: BitSize].
- out_valid  out  N  per-row valid; drives the PE in_valid.
- busy  out  1  high in STREAM or DRAIN.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (res_n low, asynchronous): out_a = 0, out_valid = 0, busy = 0, done = 0, in_ready = 1. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame discards all buffered and in-flight data. No done pulse is issued for the aborted frame.
- Handshake:
  - A push occurs on a clock edge where in_valid & in_ready.
  - in_ready = (count < Depth). It is registered-state based and does not depend on in_valid.
  - When the FIFO is full, in_ready stays low even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave count unchanged.
- FIFO:
  - Each entry stores {last, data}.
  - Circular read/write pointers with log2(Depth) bits; count is log2(Depth)+1 bits.
  - Pointers wrap from Depth-1 to 0.
- Pop condition: !stall & count != 0 & state != DRAIN.
- Skew pipeline:
  - Row i has an i-stage delay chain. Each stage holds {valid, data}, and row N-1 additionally holds last.
  - On a pop, element i of the head vector enters the first stage of row i; row 0 is the output register directly.
  - With no pop, a bubble enters: valid = 0, data = 0.
  - All stages shift every cycle unless stall = 1; under stall every stage, out_a and out_valid hold.
- Latency: a vector pushed on edge E0 into an empty FIFO with no stall is popped on E1. Row i output is visible after edge E1+i.
- FSM:
  - IDLE -> STREAM on the first pop. busy rises with that pop.
  - STREAM -> DRAIN on the edge that pops an entry with last = 1. Pops are blocked in DRAIN.
  - DRAIN -> IDLE on the cycle out_valid[N-1] = 1 with last tag = 1. done = 1 for exactly that cycle, and busy falls on the following edge.
  - If the FIFO is non-empty at DRAIN exit, the next pop occurs on the edge after done, with the FSM going through IDLE for one cycle.
  - A frame whose last vector is also its first goes IDLE -> STREAM -> DRAIN normally.
- Stall during DRAIN freezes the drain; done is delayed accordingly and never duplicated.
- in_last on an unaccepted beat is ignored.
- FIFO overflow is impossible by construction.
- Data is passed bit-exact with no arithmetic.

Test Plan:
- N=4, Depth=4, no stall. Push a single-vector frame {1,2,3,4} with last=1. Required: out_a row0 = 1 visible after E1, row1 = 2 after E2, row2 = 3 after E3, row3 = 4 after E4. done pulses in the cycle row3 is valid. busy spans E1 through done.
- Push 6 vectors back-to-back with stall held high. Required: in_ready drops after the 4th push and pushes 5–6 wait. Releasing stall pops one vector per cycle, in_ready reasserts the cycle after the first pop, and the write pointer wraps 3 -> 0 with no data lost.
- Two frames queued (A: 2 vectors, B: 1 vector). Required: no B element appears on any row before done for A. B's row0 appears two edges after A's done.
- Assert stall for 3 cycles during DRAIN of frame {9,8,7,6}. Required: out_a and out_valid hold constant while stalled. done arrives exactly 3 cycles later than with no stall, and only once.
- Drop res_n asynchronously mid-STREAM with 2 entries queued. Required: outputs go to zero immediately without waiting for a clock edge, in_ready = 1, and no done pulse. A fresh frame afterwards behaves as in the first test.
- Present in_valid with in_last = 1 while in_ready = 0. Required: that beat is not captured, and the frame ends only at the accepted last beat.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Input FIFO plus per-row skew delay lines feeding a systolic array.
// Row i is driven i cycles after row 0; frames are drained before the next one starts.
//
// state  | meaning
// IDLE   | no frame in flight; the first pop starts a frame
// STREAM | popping vectors of the current frame
// DRAIN  | last vector popped, pops blocked until it leaves row N-1
module systolic_skew_feeder #(
    parameter int BitSize = 8,
    parameter int N       = 4,
    parameter int Depth   = 4
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*BitSize-1:0] in_data,
    input  logic                 in_last,
    input  logic                 stall,
    output logic [N*BitSize-1:0] out_a,
    output logic [N-1:0]         out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(Depth);
    localparam int W  = N * BitSize;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(Depth);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W:0]    mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [W-1:0]  head_data;
    logic          head_last;
    logic [N-1:0]  last_sr;
    logic          tail_last;

    assign in_ready = (count < DEPTH_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = !stall && (count != '0) && (state != S_DRAIN);
    assign {head_last, head_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Each row is a shift register whose top stage is the output register.
    for (genvar i = 0; i < N; i++) begin : g_row
        logic [BitSize-1:0] elem_in;
        assign elem_in = pop ? head_data[i*BitSize +: BitSize] : '0;

        if (i == 0) begin : g_out
            logic [BitSize-1:0] sd;
            logic               sv;

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    sd <= '0;
                    sv <= 1'b0;
                end else if (!stall) begin
                    sd <= elem_in;
                    sv <= pop;
                end
            end

            assign out_a[i*BitSize +: BitSize] = sd;
            assign out_valid[i]                = sv;
        end else begin : g_chain
            logic [i:0][BitSize-1:0] sd;
            logic [i:0]              sv;

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    sd <= '0;
                    sv <= '0;
                end else if (!stall) begin
                    sd <= {sd[i-1:0], elem_in};
                    sv <= {sv[i-1:0], pop};
                end
            end

            assign out_a[i*BitSize +: BitSize] = sd[i];
            assign out_valid[i]                = sv[i];
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            last_sr <= '0;
        end else if (!stall) begin
            last_sr <= {last_sr[N-2:0], pop & head_last};
        end
    end

    assign tail_last = last_sr[N-1];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = head_last ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (pop && head_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Gated by stall so a frozen tail cannot repeat the pulse.
                if (!stall && out_valid[N-1] && tail_last) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a timeline table for the basic frame,
// a per-row scoreboard, and hand-written sequences for stall, framing and reset.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;
    localparam int BitSize = 8;
    localparam int N       = 4;
    localparam int Depth   = 4;
    localparam int W       = N * BitSize;

    logic         clk = 1'b0;
    logic         res_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         stall;
    logic [W-1:0] out_a;
    logic [N-1:0] out_valid;
    logic         busy;
    logic         done;

    systolic_skew_feeder #(.BitSize(BitSize), .N(N), .Depth(Depth)) dut (
        .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .stall(stall), .out_a(out_a),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } sb_t;

    typedef struct {
        logic         v;
        logic         l;
        logic [W-1:0] d;
        logic [N-1:0] ev;
        logic [W-1:0] ea;
        logic         eb;
        logic         ed;
        logic         er;
    } vec_t;

    sb_t          sb[$];
    int           rd_idx [N];
    logic         done_pending;
    logic         prev_stall;
    logic [W-1:0] last_a;
    logic [N-1:0] last_v;
    vec_t         tbl [6];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkvec(input logic [7:0] base);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[i*BitSize +: BitSize] = base + 8'(i);
        return v;
    endfunction

    task automatic sb_reset();
        sb.delete();
        for (int i = 0; i < N; i++) rd_idx[i] = 0;
        done_pending = 1'b0;
        last_a = '0;
        last_v = '0;
    endtask

    // Compares each row against the accepted vectors in order; expects done when
    // a last-tagged vector reaches row N-1 and stall is low.
    task automatic monitor();
        logic [BitSize-1:0] exp_e;
        logic               exp_done;
        logic               tail_hit;
        logic               hit_last;
        if (!res_n) return;
        tail_hit = 1'b0;
        hit_last = 1'b0;
        if (prev_stall) begin
            chk("hold out_a", 64'(out_a), 64'(last_a));
            chk("hold out_valid", 64'(out_valid), 64'(last_v));
        end else begin
            for (int i = 0; i < N; i++) begin
                if (out_valid[i]) begin
                    if (rd_idx[i] >= sb.size()) begin
                        checks++;
                        errors++;
                        $display("FAIL row%0d unexpected: got %0h expected none", i, out_a[i*BitSize +: BitSize]);
                    end else begin
                        exp_e = sb[rd_idx[i]].data[i*BitSize +: BitSize];
                        chk($sformatf("row%0d data", i), 64'(out_a[i*BitSize +: BitSize]), 64'(exp_e));
                        if (i == N-1) begin
                            tail_hit = 1'b1;
                            hit_last = sb[rd_idx[i]].last;
                        end
                        rd_idx[i]++;
                    end
                end else begin
                    chk($sformatf("row%0d bubble", i), 64'(out_a[i*BitSize +: BitSize]), 64'd0);
                end
            end
            if (tail_hit) begin
                void'(sb.pop_front());
                for (int i = 0; i < N; i++) if (rd_idx[i] > 0) rd_idx[i]--;
            end
            if (hit_last) done_pending = 1'b1;
        end
        exp_done = done_pending && !stall;
        chk("done", 64'(done), 64'(exp_done));
        if (exp_done) done_pending = 1'b0;
        last_a = out_a;
        last_v = out_valid;
    endtask

    task automatic step();
        prev_stall = stall;
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic l);
        sb_t e;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        if (v && in_ready && res_n) begin
            e.data = d;
            e.last = l;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (done) break;
        end
        chk($sformatf("%s done seen", name), 64'(done), 64'd1);
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < 6; k++) begin
            drive(tbl[k].v, tbl[k].d, tbl[k].l);
            step();
            chk($sformatf("%s[%0d] out_valid", tag, k), 64'(out_valid), 64'(tbl[k].ev));
            chk($sformatf("%s[%0d] out_a", tag, k), 64'(out_a), 64'(tbl[k].ea));
            chk($sformatf("%s[%0d] busy", tag, k), 64'(busy), 64'(tbl[k].eb));
            chk($sformatf("%s[%0d] done", tag, k), 64'(done), 64'(tbl[k].ed));
            chk($sformatf("%s[%0d] in_ready", tag, k), 64'(in_ready), 64'(tbl[k].er));
        end
        chk($sformatf("%s sb empty", tag), 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           n;
        int           bseen;
        logic         got;
        logic [W-1:0] snap_a;
        logic [N-1:0] snap_v;

        //            v     l     data          ev       out_a         busy  done  ready
        tbl[0] = '{1'b1, 1'b1, 32'h04030201, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 32'h00000000, 4'b0001, 32'h00000001, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 32'h00000000, 4'b0010, 32'h00000200, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 32'h00000000, 4'b0100, 32'h00030000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 32'h00000000, 4'b1000, 32'h04000000, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'h00000000, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b1};

        res_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; stall = 1'b0;
        prev_stall = 1'b0;
        sb_reset();
        #3;
        chk("reset out_a", 64'(out_a), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        #10;
        res_n = 1'b1;
        step();

        // single-vector frame timeline
        run_table("t1");

        // fill while stalled, then release
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2 ready before push", 64'(in_ready), 64'd1);
            drive(1'b1, mkvec(8'h20 + 8'(k*4)), 1'b0);
            step();
        end
        chk("t2 ready full", 64'(in_ready), 64'd0);
        drive(1'b1, mkvec(8'h30), 1'b0);
        step();
        chk("t2 ready held 1", 64'(in_ready), 64'd0);
        step();
        chk("t2 ready held 2", 64'(in_ready), 64'd0);
        stall = 1'b0;
        step();
        chk("t2 ready after pop", 64'(in_ready), 64'd1);
        chk("t2 row0 pop 0", 64'(out_valid[0]), 64'd1);
        drive(1'b1, mkvec(8'h30), 1'b0);
        step();
        chk("t2 row0 pop 1", 64'(out_valid[0]), 64'd1);
        drive(1'b1, mkvec(8'h34), 1'b1);
        step();
        chk("t2 row0 pop 2", 64'(out_valid[0]), 64'd1);
        drive(1'b0, '0, 1'b0);
        for (int k = 3; k < 6; k++) begin
            step();
            chk($sformatf("t2 row0 pop %0d", k), 64'(out_valid[0]), 64'd1);
        end
        wait_done("t2", 20, n);
        chk("t2 sb empty", 64'(sb.size()), 64'd0);
        step();

        // two queued frames must not interleave
        drive(1'b1, mkvec(8'hA0), 1'b0);
        step();
        drive(1'b1, mkvec(8'hA8), 1'b1);
        step();
        drive(1'b1, mkvec(8'hB0), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        bseen = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            for (int i = 0; i < N; i++)
                if (out_valid[i] && out_a[i*BitSize +: BitSize] == 8'hB0 + 8'(i)) bseen++;
            if (done) got = 1'b1;
            else step();
        end
        chk("t3 A done seen", 64'(got), 64'd1);
        chk("t3 B before A done", 64'(bseen), 64'd0);
        step();
        chk("t3 gap after done", 64'(out_valid), 64'd0);
        step();
        chk("t3 B row0 valid", 64'(out_valid[0]), 64'd1);
        chk("t3 B row0 data", 64'(out_a[7:0]), 64'hB0);
        wait_done("t3B", 10, n);
        chk("t3B latency", 64'(n), 64'd3);
        chk("t3 sb empty", 64'(sb.size()), 64'd0);
        step();

        // stall for three cycles during drain
        drive(1'b1, 32'h06070809, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        step();
        snap_a = out_a;
        snap_v = out_valid;
        chk("t4 row0 first", 64'(snap_a), 64'h09);
        chk("t4 valid first", 64'(snap_v), 64'b0001);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4 stall out_a", 64'(out_a), 64'(snap_a));
            chk("t4 stall out_valid", 64'(out_valid), 64'(snap_v));
            chk("t4 stall done", 64'(done), 64'd0);
        end
        stall = 1'b0;
        wait_done("t4", 10, n);
        chk("t4 done delay", 64'(n), 64'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4 no second done", 64'(done), 64'd0);
        end
        chk("t4 sb empty", 64'(sb.size()), 64'd0);

        // asynchronous reset mid-stream with two entries queued
        drive(1'b1, mkvec(8'h40), 1'b0);
        step();
        drive(1'b1, mkvec(8'h44), 1'b0);
        step();
        stall = 1'b1;
        drive(1'b1, mkvec(8'h48), 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        step();
        chk("t5 busy before reset", 64'(busy), 64'd1);
        chk("t5 row0 before reset", 64'(out_valid[0]), 64'd1);
        #2;
        res_n = 1'b0;
        #1;
        chk("t5 async out_a", 64'(out_a), 64'd0);
        chk("t5 async out_valid", 64'(out_valid), 64'd0);
        chk("t5 async busy", 64'(busy), 64'd0);
        chk("t5 async done", 64'(done), 64'd0);
        chk("t5 async in_ready", 64'(in_ready), 64'd1);
        sb_reset();
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t5 done in reset", 64'(done), 64'd0);
            chk("t5 valid in reset", 64'(out_valid), 64'd0);
        end
        #2;
        res_n = 1'b1;
        step();
        chk("t5 done after release", 64'(done), 64'd0);
        run_table("t5");

        // last on a refused beat is ignored
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mkvec(8'h60 + 8'(k*4)), 1'b0);
            step();
        end
        chk("t6 ready full", 64'(in_ready), 64'd0);
        drive(1'b1, {4{8'hEE}}, 1'b1);
        step();
        chk("t6 refused 1", 64'(in_ready), 64'd0);
        step();
        chk("t6 refused 2", 64'(in_ready), 64'd0);
        drive(1'b0, '0, 1'b0);
        stall = 1'b0;
        step();
        chk("t6 ready after pop", 64'(in_ready), 64'd1);
        chk("t6 busy streaming", 64'(busy), 64'd1);
        drive(1'b1, mkvec(8'h70), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        wait_done("t6", 30, n);
        chk("t6 sb empty", 64'(sb.size()), 64'd0);
        step();
        chk("t6 idle after done", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
